// File: rtl/led_switch_ctrl.sv
// led_switch_ctrl: N_CH slide switches to N_CH LEDs.
// Each switch goes through a 2-flop synchroniser and a debouncer. A registered
// mode engine then drives the LEDs in one of four modes: mirror, invert,
// toggle-latch or chase.
// Optional build macro: LED_REVERSE_EN reverses the ledr bit order at the
// output register. sw_deb and sw_evt are not affected.
module led_switch_ctrl #(
  parameter int N_CH       = 10,
  parameter int DEB_CYCLES = 16,
  parameter int CHASE_DIV  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sw,
  input  logic [1:0]      mode,
  output logic [N_CH-1:0] ledr,
  output logic [N_CH-1:0] sw_deb,
  output logic            sw_evt
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int PW = (CHASE_DIV > 1) ? $clog2(CHASE_DIV) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] DIV_LAST = PW'(CHASE_DIV - 1);

  typedef enum logic [1:0] {
    MIRROR = 2'b00,
    INVERT = 2'b01,
    TOGGLE = 2'b10,
    CHASE  = 2'b11
  } mode_t;

  mode_t           mode_in;
  mode_t           mode_q;
  logic [N_CH-1:0] sw_meta;
  logic [N_CH-1:0] sw_s;
  logic [CW-1:0]   cnt      [N_CH];
  logic [CW-1:0]   cnt_next [N_CH];
  logic [N_CH-1:0] deb_next;
  logic [N_CH-1:0] tog;
  logic [N_CH-1:0] tog_next;
  logic [N_CH-1:0] pos;
  logic [N_CH-1:0] pos_next;
  logic [PW-1:0]   presc;
  logic [PW-1:0]   presc_next;
  logic [N_CH-1:0] led_f;
  logic [N_CH-1:0] led_next;

  assign mode_in = mode_t'(mode);

  // Per-channel debounce: accept sw_s once it has differed for DEB_CYCLES edges
  always_comb begin
    deb_next = sw_deb;
    cnt_next = '{default: '0};
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (sw_s[i] != sw_deb[i]) begin
        if (cnt[i] == DEB_LAST) begin
          deb_next[i] = sw_s[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  // Mode engine next state: toggle latch, chase position/prescaler, LED function
  always_comb begin
    tog_next   = tog ^ (deb_next & ~sw_deb);
    pos_next   = pos;
    presc_next = presc;
    if (mode_in == CHASE && mode_q != CHASE) begin
      pos_next    = '0;
      pos_next[0] = 1'b1;
      presc_next  = '0;
    end else if (mode_q == CHASE) begin
      if (presc == DIV_LAST) begin
        presc_next = '0;
        pos_next   = {pos[N_CH-2:0], pos[N_CH-1]};
      end else begin
        presc_next = presc + PW'(1);
      end
    end
    case (mode_q)
      MIRROR:  led_f = sw_deb;
      INVERT:  led_f = ~sw_deb;
      TOGGLE:  led_f = tog;
      default: led_f = pos;
    endcase
    led_next = led_f;
`ifdef LED_REVERSE_EN
    for (int unsigned i = 0; i < N_CH; i++) begin
      led_next[i] = led_f[N_CH-1-i];
    end
`endif
  end

  // State and output registers; every output comes straight from a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta <= '0;
      sw_s    <= '0;
      sw_deb  <= '0;
      sw_evt  <= 1'b0;
      cnt     <= '{default: '0};
      tog     <= '0;
      pos     <= N_CH'(1);
      presc   <= '0;
      mode_q  <= MIRROR;
      ledr    <= '0;
    end else begin
      sw_meta <= sw;
      sw_s    <= sw_meta;
      sw_deb  <= deb_next;
      sw_evt  <= (deb_next != sw_deb);
      cnt     <= cnt_next;
      tog     <= tog_next;
      pos     <= pos_next;
      presc   <= presc_next;
      mode_q  <= mode_in;
      ledr    <= led_next;
    end
  end

endmodule

// File: tb/tb_led_switch_ctrl.sv
// Testbench for led_switch_ctrl (N_CH=10, DEB_CYCLES=4, CHASE_DIV=8).
// It runs directed sequences and a vector table, then random stimulus that is
// compared against a window-based behavioural model.
module tb_led_switch_ctrl;

  localparam int N    = 10;
  localparam int DEB  = 4;
  localparam int CDIV = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] sw;
  logic [1:0]   mode;
  logic [N-1:0] ledr;
  logic [N-1:0] sw_deb;
  logic         sw_evt;

  int errors = 0;
  int checks = 0;

  led_switch_ctrl #(.N_CH(N), .DEB_CYCLES(DEB), .CHASE_DIV(CDIV)) dut (
    .clk(clk), .rst(rst), .sw(sw), .mode(mode),
    .ledr(ledr), .sw_deb(sw_deb), .sw_evt(sw_evt)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [N-1:0] rev(input logic [N-1:0] x);
    logic [N-1:0] r;
    r = x;
`ifdef LED_REVERSE_EN
    for (int i = 0; i < N; i++) r[i] = x[N-1-i];
`endif
    return r;
  endfunction

  task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: sw_deb flips once the last DEB synchronised samples all disagree with it;
  // toggle = parity of rising edges; chase position = elapsed steps mod N.
  logic [N-1:0] m_s1, m_s2, m_deb, m_tog, m_ledr;
  logic         m_evt;
  logic [1:0]   m_mq;
  int unsigned  m_t;
  logic [N-1:0] m_hist[$];

  task automatic model_step();
    logic [N-1:0] nd, f, pos;
    bit all;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_tog = '0; m_ledr = '0;
      m_evt = 1'b0; m_mq = 2'd0; m_t = 0;
      m_hist.delete();
    end else begin
      m_hist.push_back(m_s2);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      nd = m_deb;
      if (m_hist.size() == DEB) begin
        for (int i = 0; i < N; i++) begin
          all = 1'b1;
          foreach (m_hist[k]) if (m_hist[k][i] == m_deb[i]) all = 1'b0;
          if (all) nd[i] = ~m_deb[i];
        end
      end
      pos = '0;
      pos[(m_t / CDIV) % N] = 1'b1;
      case (m_mq)
        2'd0:    f = m_deb;
        2'd1:    f = ~m_deb;
        2'd2:    f = m_tog;
        default: f = pos;
      endcase
      m_ledr = rev(f);
      m_evt  = (nd != m_deb);
      m_tog  = m_tog ^ (nd & ~m_deb);
      if (m_mq != 2'd3 && mode == 2'd3) m_t = 0;
      else if (m_mq == 2'd3) m_t++;
      m_mq  = mode;
      m_deb = nd;
      m_s2  = m_s1;
      m_s1  = sw;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] sw;
    logic [1:0]   mode;
    int           cyc;
    logic [N-1:0] ledr;
    logic [N-1:0] deb;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [N-1:0] e;

    tbl[0]  = '{1'b1, 10'h000, 2'd0, 3,  10'h000, 10'h000};
    tbl[1]  = '{1'b0, 10'h2AA, 2'd1, 10, 10'h155, 10'h2AA};
    tbl[2]  = '{1'b0, 10'h2AA, 2'd0, 10, 10'h2AA, 10'h2AA};
    tbl[3]  = '{1'b0, 10'h2AA, 2'd1, 10, 10'h155, 10'h2AA};
    tbl[4]  = '{1'b1, 10'h000, 2'd2, 3,  10'h000, 10'h000};
    tbl[5]  = '{1'b0, 10'h008, 2'd2, 10, 10'h008, 10'h008};
    tbl[6]  = '{1'b0, 10'h000, 2'd2, 10, 10'h008, 10'h000};
    tbl[7]  = '{1'b0, 10'h008, 2'd2, 10, 10'h000, 10'h008};
    tbl[8]  = '{1'b0, 10'h000, 2'd2, 10, 10'h000, 10'h000};
    tbl[9]  = '{1'b0, 10'h201, 2'd2, 10, 10'h201, 10'h201};
    tbl[10] = '{1'b0, 10'h201, 2'd0, 10, 10'h201, 10'h201};
    tbl[11] = '{1'b0, 10'h000, 2'd0, 10, 10'h000, 10'h000};
    tbl[12] = '{1'b0, 10'h000, 2'd2, 10, 10'h201, 10'h000};
    tbl[13] = '{1'b0, 10'h3FF, 2'd1, 10, 10'h000, 10'h3FF};
    tbl[14] = '{1'b0, 10'h3FF, 2'd2, 10, 10'h1FE, 10'h3FF};

    // Reset with switches held high, then the release latency
    rst = 1'b1; sw = 10'h3FF; mode = 2'd0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_ledr", ledr, '0);
      check("rst_evt", 10'(sw_evt), '0);
      check("rst_deb", sw_deb, '0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("rel_deb", sw_deb, (k >= 6) ? 10'h3FF : 10'h000);
      check("rel_evt", 10'(sw_evt), (k == 6) ? 10'd1 : 10'd0);
      check("rel_ledr", ledr, (k >= 7) ? rev(10'h3FF) : 10'h000);
    end

    // Glitch rejection in MIRROR
    sw = '0;
    for (int c = 0; c < 10; c++) tick();
    check("glitch_pre_deb", sw_deb, '0);
    sw = 10'h001;
    for (int c = 0; c < 2; c++) tick();
    sw = 10'h000;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("glitch_deb", sw_deb, '0);
      check("glitch_evt", 10'(sw_evt), '0);
    end
    sw = 10'h001;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("glitch_hold_deb", sw_deb, '0);
      check("glitch_hold_evt", 10'(sw_evt), '0);
    end
    tick();
    check("glitch_acc_deb", sw_deb, 10'h001);
    check("glitch_acc_evt", 10'(sw_evt), 10'd1);
    tick();
    check("glitch_ledr", ledr, rev(10'h001));

    // Vector table
    foreach (tbl[v]) begin
      rst = tbl[v].rst; sw = tbl[v].sw; mode = tbl[v].mode;
      for (int c = 0; c < tbl[v].cyc; c++) tick();
      check($sformatf("tbl%0d_ledr", v), ledr, rev(tbl[v].ledr));
      check($sformatf("tbl%0d_deb", v), sw_deb, tbl[v].deb);
      check($sformatf("tbl%0d_evt", v), 10'(sw_evt), '0);
    end
    rst = 1'b0;

    // Mode change reaches ledr exactly two cycles later
    mode = 2'd0;
    tick();
    check("mode_lat1", ledr, rev(10'h1FE));
    tick();
    check("mode_lat2", ledr, rev(10'h3FF));

    // Chase entry, stepping and wrap
    mode = 2'd3;
    tick();
    for (int s = 0; s < 11; s++) begin
      for (int c = 0; c < CDIV; c++) begin
        tick();
        e = '0; e[s % N] = 1'b1;
        check("chase_step", ledr, rev(e));
      end
    end

    // Reset mid-chase, then re-entry
    rst = 1'b1;
    tick();
    check("chase_rst_ledr", ledr, '0);
    check("chase_rst_deb", sw_deb, '0);
    rst = 1'b0;
    tick();
    check("chase_reentry0", ledr, '0);
    for (int c = 0; c < CDIV; c++) begin
      tick();
      check("chase_reentry", ledr, rev(10'h001));
    end
    tick();
    check("chase_reentry_step", ledr, rev(10'h002));

    // Random stimulus against the model
    rst = 1'b1;
    tick(); tick();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 2) == 0) sw[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      tick();
      check("rnd_ledr", ledr, m_ledr);
      check("rnd_deb", sw_deb, m_deb);
      check("rnd_evt", 10'(sw_evt), 10'(m_evt));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
